// File: rtl/dcache_data_arb.sv
// Arbiter/sequencer for the single port of the 4-way D-cache data array.
// Shares the port between CPU accesses, 4-beat refill write bursts and
// 4-beat writeback read bursts, and routes each read response (one cycle
// later) back to the requester that issued the read.
module dcache_data_arb (
  input  logic        clock,
  input  logic        reset,
  // CPU port
  input  logic        io_cpu_req_valid,
  output logic        io_cpu_req_ready,
  input  logic [11:0] io_cpu_req_bits_addr,
  input  logic        io_cpu_req_bits_write,
  input  logic [31:0] io_cpu_req_bits_wdata,
  input  logic [3:0]  io_cpu_req_bits_mask,
  input  logic [3:0]  io_cpu_req_bits_way_en,
  output logic        io_cpu_resp_valid,
  output logic [31:0] io_cpu_resp_0,
  output logic [31:0] io_cpu_resp_1,
  output logic [31:0] io_cpu_resp_2,
  output logic [31:0] io_cpu_resp_3,
  // Refill port
  input  logic        io_refill_valid,
  output logic        io_refill_ready,
  input  logic [7:0]  io_refill_bits_line,
  input  logic [3:0]  io_refill_bits_way_en,
  input  logic [31:0] io_refill_bits_data,
  output logic        io_refill_done,
  // Writeback port
  input  logic        io_wb_req_valid,
  output logic        io_wb_req_ready,
  input  logic [7:0]  io_wb_req_bits_line,
  input  logic [3:0]  io_wb_req_bits_way_en,
  output logic        io_wb_data_valid,
  output logic [31:0] io_wb_data,
  output logic [1:0]  io_wb_beat,
  // Data array port
  output logic        io_array_req_valid,
  output logic [11:0] io_array_req_bits_addr,
  output logic        io_array_req_bits_write,
  output logic [31:0] io_array_req_bits_wdata,
  output logic [3:0]  io_array_req_bits_eccMask,
  output logic [3:0]  io_array_req_bits_way_en,
  input  logic [31:0] io_array_resp_0,
  input  logic [31:0] io_array_resp_1,
  input  logic [31:0] io_array_resp_2,
  input  logic [31:0] io_array_resp_3
);

  typedef enum logic [1:0] {StIdle, StRefill, StWb} state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnWb} owner_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  line_q, line_d;
  logic [3:0]  way_q, way_d;
  logic        starve_q, starve_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  wb_way_q, wb_way_d;
  logic [1:0]  beat_q, beat_d;

  logic        cpu_wins;
  logic [31:0] wb_word;

  // CPU beats refill/wb only when it was starved by the previous burst,
  // or when nobody else is asking.
  assign cpu_wins = io_cpu_req_valid &
                    (starve_q | (~io_refill_valid & ~io_wb_req_valid));

  // Grant, burst sequencing and array request generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    way_d     = way_q;
    starve_d  = starve_q;
    owner_d   = OwnNone;
    wb_way_d  = wb_way_q;
    beat_d    = beat_q;

    io_cpu_req_ready          = 1'b0;
    io_refill_ready           = 1'b0;
    io_refill_done            = 1'b0;
    io_wb_req_ready           = 1'b0;
    io_array_req_valid        = 1'b0;
    io_array_req_bits_addr    = '0;
    io_array_req_bits_write   = 1'b0;
    io_array_req_bits_wdata   = '0;
    io_array_req_bits_eccMask = '0;
    io_array_req_bits_way_en  = '0;

    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (cpu_wins) begin
            io_cpu_req_ready          = 1'b1;
            io_array_req_valid        = 1'b1;
            io_array_req_bits_addr    = io_cpu_req_bits_addr;
            io_array_req_bits_write   = io_cpu_req_bits_write;
            io_array_req_bits_wdata   = io_cpu_req_bits_wdata;
            io_array_req_bits_eccMask = io_cpu_req_bits_mask;
            io_array_req_bits_way_en  = io_cpu_req_bits_way_en;
            owner_d  = io_cpu_req_bits_write ? OwnNone : OwnCpu;
            starve_d = 1'b0;
          end else if (io_refill_valid) begin
            io_refill_ready           = 1'b1;
            io_array_req_valid        = 1'b1;
            io_array_req_bits_addr    = {io_refill_bits_line, 2'b00, 2'b00};
            io_array_req_bits_write   = 1'b1;
            io_array_req_bits_wdata   = io_refill_bits_data;
            io_array_req_bits_eccMask = 4'hF;
            io_array_req_bits_way_en  = io_refill_bits_way_en;
            line_d  = io_refill_bits_line;
            way_d   = io_refill_bits_way_en;
            cnt_d   = 2'd1;
            state_d = StRefill;
          end else if (io_wb_req_valid) begin
            io_wb_req_ready           = 1'b1;
            io_array_req_valid        = 1'b1;
            io_array_req_bits_addr    = {io_wb_req_bits_line, 2'b00, 2'b00};
            io_array_req_bits_way_en  = io_wb_req_bits_way_en;
            line_d   = io_wb_req_bits_line;
            way_d    = io_wb_req_bits_way_en;
            wb_way_d = io_wb_req_bits_way_en;
            owner_d  = OwnWb;
            beat_d   = 2'd0;
            cnt_d    = 2'd1;
            state_d  = StWb;
          end
          if (!io_cpu_req_valid) starve_d = 1'b0;
        end

        StRefill: begin
          io_refill_ready = 1'b1;
          if (io_refill_valid) begin
            io_array_req_valid        = 1'b1;
            io_array_req_bits_addr    = {line_q, cnt_q, 2'b00};
            io_array_req_bits_write   = 1'b1;
            io_array_req_bits_wdata   = io_refill_bits_data;
            io_array_req_bits_eccMask = 4'hF;
            io_array_req_bits_way_en  = way_q;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              io_refill_done = 1'b1;
              starve_d       = 1'b1;
              state_d        = StIdle;
            end
          end
        end

        StWb: begin
          // Reads stream back-to-back; the wb consumer cannot stall.
          io_array_req_valid       = 1'b1;
          io_array_req_bits_addr   = {line_q, cnt_q, 2'b00};
          io_array_req_bits_way_en = way_q;
          owner_d = OwnWb;
          beat_d  = cnt_q;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            starve_d = 1'b1;
            state_d  = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // Burst context, starve flag and read-owner tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      line_q   <= 8'd0;
      way_q    <= 4'd0;
      starve_q <= 1'b0;
      owner_q  <= OwnNone;
      wb_way_q <= 4'd0;
      beat_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      way_q    <= way_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      wb_way_q <= wb_way_d;
      beat_q   <= beat_d;
    end
  end

  // Select the word of the latched writeback way (way_en is one-hot).
  always_comb begin
    wb_word = '0;
    if (wb_way_q[0]) wb_word = wb_word | io_array_resp_0;
    if (wb_way_q[1]) wb_word = wb_word | io_array_resp_1;
    if (wb_way_q[2]) wb_word = wb_word | io_array_resp_2;
    if (wb_way_q[3]) wb_word = wb_word | io_array_resp_3;
  end

  assign io_cpu_resp_valid = (owner_q == OwnCpu) & ~reset;
  assign io_cpu_resp_0     = io_array_resp_0;
  assign io_cpu_resp_1     = io_array_resp_1;
  assign io_cpu_resp_2     = io_array_resp_2;
  assign io_cpu_resp_3     = io_array_resp_3;
  assign io_wb_data_valid  = (owner_q == OwnWb) & ~reset;
  assign io_wb_data        = wb_word;
  assign io_wb_beat        = beat_q;

endmodule

// File: tb/tb_dcache_data_arb.sv
// Bench for dcache_data_arb: grant table, directed burst sequences and a
// randomized run, all checked against a transaction-level model.
module tb_dcache_data_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_v, cpu_rdy, cpu_w, cpu_rv;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_mask, cpu_way;
  logic [31:0] cpu_r0, cpu_r1, cpu_r2, cpu_r3;
  logic        rf_v, rf_rdy, rf_done;
  logic [7:0]  rf_line;
  logic [3:0]  rf_way;
  logic [31:0] rf_data;
  logic        wb_v, wb_rdy, wb_dv;
  logic [7:0]  wb_line;
  logic [3:0]  wb_way;
  logic [31:0] wb_data;
  logic [1:0]  wb_beat;
  logic        a_v, a_w;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_mask, a_way;
  logic [31:0] ar [4];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  dcache_data_arb dut (
    .clock(clock), .reset(reset),
    .io_cpu_req_valid(cpu_v), .io_cpu_req_ready(cpu_rdy),
    .io_cpu_req_bits_addr(cpu_addr), .io_cpu_req_bits_write(cpu_w),
    .io_cpu_req_bits_wdata(cpu_wdata), .io_cpu_req_bits_mask(cpu_mask),
    .io_cpu_req_bits_way_en(cpu_way), .io_cpu_resp_valid(cpu_rv),
    .io_cpu_resp_0(cpu_r0), .io_cpu_resp_1(cpu_r1),
    .io_cpu_resp_2(cpu_r2), .io_cpu_resp_3(cpu_r3),
    .io_refill_valid(rf_v), .io_refill_ready(rf_rdy),
    .io_refill_bits_line(rf_line), .io_refill_bits_way_en(rf_way),
    .io_refill_bits_data(rf_data), .io_refill_done(rf_done),
    .io_wb_req_valid(wb_v), .io_wb_req_ready(wb_rdy),
    .io_wb_req_bits_line(wb_line), .io_wb_req_bits_way_en(wb_way),
    .io_wb_data_valid(wb_dv), .io_wb_data(wb_data), .io_wb_beat(wb_beat),
    .io_array_req_valid(a_v), .io_array_req_bits_addr(a_addr),
    .io_array_req_bits_write(a_w), .io_array_req_bits_wdata(a_wdata),
    .io_array_req_bits_eccMask(a_mask), .io_array_req_bits_way_en(a_way),
    .io_array_resp_0(ar[0]), .io_array_resp_1(ar[1]),
    .io_array_resp_2(ar[2]), .io_array_resp_3(ar[3])
  );

  typedef struct packed {
    logic        cpu_rdy, rf_rdy, wb_rdy, done, av, aw, cpu_rv, wb_dv;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask, way;
    logic [31:0] wb_data;
    logic [1:0]  wb_beat;
  } exp_t;

  // Reference model: pending wb reads as an address queue, refill progress
  // as the next beat number, and the kind of read issued last cycle.
  bit          m_starve;
  int          m_rf_beat;   // 0: no refill in progress, else next beat
  logic [7:0]  m_line;
  logic [3:0]  m_way;
  logic [11:0] m_wbq [$];
  int          m_resp;      // 0 none, 1 cpu load, 2 wb beat
  int          m_resp_beat;
  logic [3:0]  m_wb_way;

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic model_step(output exp_t e);
    logic [11:0] a;
    bit cpu_turn;
    e = '0;
    if (reset) begin
      m_starve = 0; m_rf_beat = 0; m_wbq.delete(); m_resp = 0;
      return;
    end
    if (m_resp == 1) e.cpu_rv = 1'b1;
    if (m_resp == 2) begin
      e.wb_dv = 1'b1;
      e.wb_data = ar[oh_idx(m_wb_way)];
      e.wb_beat = m_resp_beat[1:0];
    end
    m_resp = 0;
    if (m_wbq.size() > 0) begin
      a = m_wbq.pop_front();
      e.av = 1'b1; e.addr = a;
      m_resp = 2; m_resp_beat = int'(a[3:2]);
      if (m_wbq.size() == 0) m_starve = 1;
    end else if (m_rf_beat > 0) begin
      e.rf_rdy = 1'b1;
      if (rf_v) begin
        e.av = 1'b1; e.aw = 1'b1; e.addr = {m_line, m_rf_beat[1:0], 2'b00};
        e.wdata = rf_data; e.mask = 4'hF; e.way = m_way;
        if (m_rf_beat == 3) begin
          e.done = 1'b1; m_starve = 1; m_rf_beat = 0;
        end else m_rf_beat++;
      end
    end else begin
      cpu_turn = cpu_v && (m_starve || (!rf_v && !wb_v));
      if (cpu_turn) begin
        e.cpu_rdy = 1'b1; e.av = 1'b1; e.aw = cpu_w; e.addr = cpu_addr;
        e.wdata = cpu_wdata; e.mask = cpu_mask; e.way = cpu_way;
        if (!cpu_w) m_resp = 1;
        m_starve = 0;
      end else if (rf_v) begin
        e.rf_rdy = 1'b1; e.av = 1'b1; e.aw = 1'b1; e.addr = {rf_line, 4'h0};
        e.wdata = rf_data; e.mask = 4'hF; e.way = rf_way;
        m_line = rf_line; m_way = rf_way; m_rf_beat = 1;
      end else if (wb_v) begin
        e.wb_rdy = 1'b1; e.av = 1'b1; e.addr = {wb_line, 4'h0};
        for (int b = 1; b < 4; b++) m_wbq.push_back({wb_line, b[1:0], 2'b00});
        m_wb_way = wb_way; m_resp = 2; m_resp_beat = 0;
      end
      if (!cpu_v) m_starve = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Settle, run the model for this cycle and compare every output.
  task automatic step();
    exp_t e;
    #1;
    model_step(e);
    chk("cpu_ready", 32'(cpu_rdy), 32'(e.cpu_rdy));
    chk("refill_ready", 32'(rf_rdy), 32'(e.rf_rdy));
    chk("wb_ready", 32'(wb_rdy), 32'(e.wb_rdy));
    chk("refill_done", 32'(rf_done), 32'(e.done));
    chk("array_valid", 32'(a_v), 32'(e.av));
    chk("cpu_resp_valid", 32'(cpu_rv), 32'(e.cpu_rv));
    chk("wb_data_valid", 32'(wb_dv), 32'(e.wb_dv));
    if (e.av) begin
      chk("array_addr", 32'(a_addr), 32'(e.addr));
      chk("array_write", 32'(a_w), 32'(e.aw));
    end
    if (e.av && e.aw) begin
      chk("array_wdata", a_wdata, e.wdata);
      chk("array_mask", 32'(a_mask), 32'(e.mask));
      chk("array_way", 32'(a_way), 32'(e.way));
    end
    if (e.cpu_rv) begin
      chk("cpu_resp_0", cpu_r0, ar[0]);
      chk("cpu_resp_3", cpu_r3, ar[3]);
    end
    if (e.wb_dv) begin
      chk("wb_data", wb_data, e.wb_data);
      chk("wb_beat", 32'(wb_beat), 32'(e.wb_beat));
    end
  endtask

  task automatic quiet();
    reset = 0; cpu_v = 0; rf_v = 0; wb_v = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); quiet(); reset = 1; step();
  endtask

  typedef struct {
    bit rv, wv, cv, cw;
    bit e_av, e_rr, e_wr, e_cr, e_w;
    logic [11:0] e_addr;
  } vec_t;

  vec_t vt [8];

  initial begin
    quiet();
    cpu_addr = 0; cpu_w = 0; cpu_wdata = 0; cpu_mask = 0; cpu_way = 0;
    rf_line = 0; rf_way = 0; rf_data = 0; wb_line = 0; wb_way = 0;
    for (int i = 0; i < 4; i++) ar[i] = 32'h0;
    reset = 1;
    m_starve = 0; m_rf_beat = 0; m_resp = 0; m_resp_beat = 0;
    m_line = 0; m_way = 0; m_wb_way = 0;

    // Reset state: everything quiet while reset is held.
    @(negedge clock); reset = 1; cpu_v = 1; rf_v = 1; wb_v = 1; step();
    chk("reset_array_valid", 32'(a_v), 32'h0);
    chk("reset_readies", {29'h0, cpu_rdy, rf_rdy, wb_rdy}, 32'h0);

    // Single-cycle IDLE grant decisions, each from a fresh reset.
    vt[0] = '{0,0,0,0, 0,0,0,0,0, 12'h000};
    vt[1] = '{0,0,1,0, 1,0,0,1,0, 12'h124};
    vt[2] = '{0,0,1,1, 1,0,0,1,1, 12'h124};
    vt[3] = '{0,1,1,0, 1,0,1,0,0, 12'h3F0};
    vt[4] = '{1,1,1,0, 1,1,0,0,1, 12'h120};
    vt[5] = '{1,0,0,0, 1,1,0,0,1, 12'h120};
    vt[6] = '{0,1,0,0, 1,0,1,0,0, 12'h3F0};
    vt[7] = '{1,0,1,1, 1,1,0,0,1, 12'h120};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      @(negedge clock);
      quiet();
      rf_v = vt[i].rv; wb_v = vt[i].wv; cpu_v = vt[i].cv; cpu_w = vt[i].cw;
      rf_line = 8'h12; rf_way = 4'b0100; wb_line = 8'h3F; wb_way = 4'b0010;
      cpu_addr = 12'h124; cpu_mask = 4'hF; cpu_way = 4'b0001;
      step();
      chk("tbl_array_valid", 32'(a_v), 32'(vt[i].e_av));
      chk("tbl_grants", {29'h0, rf_rdy, wb_rdy, cpu_rdy},
          {29'h0, vt[i].e_rr, vt[i].e_wr, vt[i].e_cr});
      if (vt[i].e_av) begin
        chk("tbl_addr", 32'(a_addr), 32'(vt[i].e_addr));
        chk("tbl_write", 32'(a_w), 32'(vt[i].e_w));
      end
    end

    // Load: read of 0x124, response next cycle.
    do_reset();
    @(negedge clock); quiet(); cpu_v = 1; cpu_w = 0; cpu_addr = 12'h124; step();
    chk("load_addr", 32'(a_addr), 32'h124);
    chk("load_write", 32'(a_w), 32'h0);
    @(negedge clock); quiet();
    ar[0] = 32'hA0A0_0000; ar[1] = 32'hA1A1_1111; ar[2] = 32'hA2A2_2222; ar[3] = 32'hA3A3_3333;
    step();
    chk("load_resp_valid", 32'(cpu_rv), 32'h1);
    chk("load_resp_1", cpu_r1, 32'hA1A1_1111);
    chk("load_resp_2", cpu_r2, 32'hA2A2_2222);

    // Refill: line 0x12, way 0100, gap after beat 1; CPU held valid.
    do_reset();
    begin
      logic [11:0] ra [5];
      bit          rv [5];
      ra = '{12'h120, 12'h124, 12'h000, 12'h128, 12'h12C};
      rv = '{1, 1, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        @(negedge clock); quiet();
        cpu_v = 1; cpu_w = 0; cpu_addr = 12'h004;
        rf_v = rv[i]; rf_data = 32'hF00D_0000 + 32'(i);
        // Line/way only count on beat 0; later beats carry junk.
        rf_line = (i == 0) ? 8'h12 : 8'h77;
        rf_way  = (i == 0) ? 4'b0100 : 4'b0001;
        step();
        chk("refill_cpu_ready", 32'(cpu_rdy), 32'h0);
        chk("refill_done_beat", 32'(rf_done), (i == 4) ? 32'h1 : 32'h0);
        if (rv[i]) begin
          chk("refill_addr", 32'(a_addr), 32'(ra[i]));
          chk("refill_way", 32'(a_way), 32'h4);
          chk("refill_mask", 32'(a_mask), 32'hF);
        end
      end
    end

    // Writeback: line 0x3F, way 0010.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); quiet();
      wb_v = (i == 0); wb_line = 8'h3F; wb_way = 4'b0010;
      ar[0] = 32'h0; ar[1] = 32'h1111_0000 + 32'(i); ar[2] = 32'h2222_2222; ar[3] = 32'h3333_3333;
      step();
      if (i < 4) chk("wb_read_addr", 32'(a_addr), 32'h3F0 + 32'(4 * i));
      chk("wb_dv_cycle", 32'(wb_dv), (i > 0) ? 32'h1 : 32'h0);
      if (i > 0) begin
        chk("wb_word", wb_data, 32'h1111_0000 + 32'(i));
        chk("wb_beat_idx", 32'(wb_beat), 32'(i - 1));
      end
    end

    // Store: one write, no response.
    do_reset();
    @(negedge clock); quiet();
    cpu_v = 1; cpu_w = 1; cpu_addr = 12'h2A8; cpu_wdata = 32'hDEAD_BEEF;
    cpu_mask = 4'b0011; cpu_way = 4'b1000;
    step();
    chk("store_mask", 32'(a_mask), 32'h3);
    chk("store_way", 32'(a_way), 32'h8);
    chk("store_write", 32'(a_w), 32'h1);
    @(negedge clock); quiet(); step();
    chk("store_no_resp", 32'(cpu_rv), 32'h0);

    // Contention: refill, then starved CPU, then wb burst, then CPU.
    do_reset();
    begin
      logic [2:0] eg [11];
      eg = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010,
             3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
      for (int i = 0; i < 11; i++) begin
        @(negedge clock); quiet();
        rf_v = (i < 4); rf_line = 8'h20; rf_way = 4'b0001;
        wb_v = (i < 6); wb_line = 8'h30; wb_way = 4'b0100;
        cpu_v = 1; cpu_w = 0; cpu_addr = 12'h500;
        step();
        chk("contention_grant", {29'h0, rf_rdy, wb_rdy, cpu_rdy}, {29'h0, eg[i]});
      end
    end

    // Reset after two refill beats, then a fresh refill.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); quiet(); rf_v = 1; rf_line = 8'h12; rf_way = 4'b0100; step();
    end
    @(negedge clock); quiet(); rf_v = 1; reset = 1; step();
    chk("rst_mid_array", 32'(a_v), 32'h0);
    chk("rst_mid_ready", 32'(rf_rdy), 32'h0);
    @(negedge clock); quiet(); step();
    chk("post_rst_idle", {30'h0, a_v, rf_rdy}, 32'h0);
    @(negedge clock); quiet(); rf_v = 1; rf_line = 8'h05; rf_way = 4'b0001; step();
    chk("restart_addr", 32'(a_addr), 32'h050);
    chk("restart_way", 32'(a_way), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset = ($urandom_range(149) == 0);
      rf_v = ($urandom_range(9) < 3); wb_v = ($urandom_range(9) < 2);
      cpu_v = ($urandom_range(9) < 6);
      rf_line = 8'($urandom); rf_way = 4'b0001 << $urandom_range(3); rf_data = $urandom;
      wb_line = 8'($urandom); wb_way = 4'b0001 << $urandom_range(3);
      cpu_addr = 12'($urandom); cpu_w = 1'($urandom); cpu_wdata = $urandom;
      cpu_mask = 4'($urandom); cpu_way = 4'b0001 << $urandom_range(3);
      for (int k = 0; k < 4; k++) ar[k] = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_data_arb.md
# dcache_data_arb

Arbiter and sequencer in front of the 4-way D-cache data array (1024 words × 4 ways, synchronous read, one access per cycle). Shares the single array port between three requesters: CPU load/store, line refill (4-beat write burst) and writeback drain (4-beat read burst). Tracks which requester owns each in-flight read so the next-cycle array response is routed correctly. Lines are 16 bytes; the word index is addr[11:2] and the beat is addr[3:2].

## Interface
- No parameters. Line = 4 words, ways = 4, read latency = 1; all fixed.
- clock  in  1  sole clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high.
- io_cpu_req_valid / io_cpu_req_ready  in/out  1  CPU request handshake.
- io_cpu_req_bits_addr  in  12  byte address.
- io_cpu_req_bits_write  in  1  store when 1.
- io_cpu_req_bits_wdata  in  32  store data.
- io_cpu_req_bits_mask  in  4  byte enables for the store.
- io_cpu_req_bits_way_en  in  4  one-hot target way for the store.
- io_cpu_resp_valid  out  1  load data valid.
- io_cpu_resp_0..3  out  32 each  load word from ways 0..3.
- io_refill_valid / io_refill_ready  in/out  1  refill beat handshake.
- io_refill_bits_line  in  8  line index, addr[11:4]; sampled on beat 0 only.
- io_refill_bits_way_en  in  4  one-hot way; sampled on beat 0 only.
- io_refill_bits_data  in  32  beat data.
- io_refill_done  out  1  one-cycle pulse when beat 3 is accepted.
- io_wb_req_valid / io_wb_req_ready  in/out  1  writeback line request.
- io_wb_req_bits_line  in  8  line index to drain.
- io_wb_req_bits_way_en  in  4  one-hot source way.
- io_wb_data_valid  out  1  writeback beat valid; there is no backpressure.
- io_wb_data  out  32  beat word from the selected way.
- io_wb_beat  out  2  beat index of io_wb_data.
- io_array_req_valid, io_array_req_bits_addr[11:0], io_array_req_bits_write, io_array_req_bits_wdata[31:0], io_array_req_bits_eccMask[3:0], io_array_req_bits_way_en[3:0]  out  data-array request.
- io_array_resp_0..3  in  32 each  array read data, valid one cycle after the read.

## Operation
- States:
  - IDLE
  - REFILL: beats 1..3 remaining
  - WB: beats 1..3 remaining
- A 2-bit beat counter, a latched line and a latched way_en register hold the burst context.
- IDLE grant, combinational, one grant per cycle:
  - Priority is refill > wb > cpu.
  - Exception: when the starve flag is set and io_cpu_req_valid=1, the CPU wins.
- Refill grant:
  - io_refill_ready=1; accept beat 0.
  - Write addr = {line, 2'b00, 2'b00}, eccMask=4'hF, way_en latched.
  - If the beat is accepted, go to REFILL with counter=1.
- REFILL:
  - io_refill_ready=1; all other readies are 0.
  - Each accepted beat writes {line_q, cnt, 2'b00}.
  - A cycle with no beat leaves the array idle and holds the state.
  - The beat-3 accept pulses io_refill_done, sets starve, and returns to IDLE.
- WB grant:
  - io_wb_req_ready=1; issue the read of beat 0 in the same cycle.
  - Go to WB with counter=1.
  - WB issues reads for beats 1, 2, 3 on consecutive cycles; no stalls are allowed.
  - After the beat-3 read, set starve and return to IDLE.
- CPU grant:
  - io_cpu_req_ready=1; pass addr/write/wdata/mask/way_en straight to the array.
  - The CPU grant clears starve.
  - Starve also clears in IDLE when io_cpu_req_valid=0.
- Response routing: a registered read owner (none/cpu/wb), registered wb way and registered beat.
  - Owner cpu gives io_cpu_resp_valid=1 and io_cpu_resp_0..3 = io_array_resp_0..3.
  - Owner wb gives io_wb_data_valid=1, io_wb_data = the io_array_resp word of the latched way, and io_wb_beat = the registered beat.
  - Writes set owner to none.
- io_array_req_valid=1 exactly in the cycles where a grant or burst beat issues.

## Timing
- Reset:
  - State IDLE, counter 0, starve 0, owner none.
  - All valids, readies and io_refill_done are 0 while reset=1.
  - The array request is 0 while reset=1.
- Load latency: accepted in cycle N, io_cpu_resp_valid in N+1.
- Writeback: request accepted in N; data beats 0..3 in N+1..N+4.
  - The array is free to other requesters from N+4.
- Refill: 4 accepted beats, possibly with gaps. io_refill_done is asserted in the same cycle as the beat-3 accept.
- Reset mid-burst: abort immediately and return to IDLE. Pending response valids are dropped the next cycle, and a partially written line is left as is.
- A simultaneous refill, wb and cpu request in IDLE with starve=0 goes to refill. After that burst, the CPU is granted before the wb request.

## Test plan
- Load: cpu read of addr 0x124 in cycle 5.
  - Required: io_array_req_bits_addr=0x124 and write=0 in cycle 5.
  - Required: io_cpu_resp_valid=1 in cycle 6 with io_cpu_resp_0..3 equal to the array data.
- Refill: line 0x12, way_en 4'b0100, 4 beats with one idle gap after beat 1.
  - Required: writes to addresses 0x120, 0x124, 0x128, 0x12C with eccMask F and way_en 0100.
  - Required: io_refill_done on beat 3 only.
  - Required: io_cpu_req_ready=0 throughout the burst.
- Writeback: line 0x3F, way_en 4'b0010, accepted in cycle 10.
  - Required: reads of 0x3F0..0x3FC in cycles 10..13.
  - Required: io_wb_data_valid in cycles 11..14 with io_wb_data = io_array_resp_1 and io_wb_beat = 0..3.
- Contention: refill, wb and cpu all valid.
  - Required order: refill burst, then one cpu access (starve), then the wb burst, then further cpu accesses.
- Store: cpu write with mask 4'b0011 and way_en 4'b1000.
  - Required: a single array write with eccMask 0011 and way_en 1000.
  - Required: no io_cpu_resp_valid.
- Reset: assert reset after 2 refill beats.
  - Required: next cycle is IDLE with all outputs 0.
  - Required: a following refill restarts at beat 0 with the line and way sampled again.
